// File: rtl/instr_decode_seq_pkg.sv
// Shared opcode constants, FSM state type and decode helpers for the
// instr_decode_seq multicycle decode/sequencer stage.
package instr_decode_seq_pkg;

   localparam logic [5:0] OP_R      = 6'h00;
   localparam logic [5:0] OP_REGIMM = 6'h01;
   localparam logic [5:0] OP_J      = 6'h02;
   localparam logic [5:0] OP_JAL    = 6'h03;
   localparam logic [5:0] OP_BEQ    = 6'h04;
   localparam logic [5:0] OP_BNE    = 6'h05;
   localparam logic [5:0] OP_ANDI   = 6'h0C;
   localparam logic [5:0] OP_ORI    = 6'h0D;
   localparam logic [5:0] OP_XORI   = 6'h0E;
   localparam logic [5:0] OP_LUI    = 6'h0F;
   localparam logic [5:0] OP_SW     = 6'h2B;

   localparam logic [5:0] FUNCT_JR  = 6'h08;

   // Opcode 2 is a J no-op for the register file; 0 is its read/write opcode.
   localparam logic [5:0] RF_NOP_OPCODE = 6'd2;
   localparam logic [5:0] RF_RW_OPCODE  = 6'd0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_CAPT,
      ST_ISSUE,
      ST_WB,
      ST_WRITE
   } state_t;

   function automatic logic is_jtype(input logic [5:0] op);
      return (op == OP_J) || (op == OP_JAL);
   endfunction

   // Instructions whose result never comes back through write-back.
   function automatic logic no_writeback(input logic [5:0] op, input logic [5:0] funct);
      return is_jtype(op) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW) ||
             ((op == OP_R) && (funct == FUNCT_JR));
   endfunction

endpackage

// File: rtl/instr_decode_seq_imm_extend.sv
// Combinational immediate extender: zero-extend for logical immediates,
// upper placement for lui, sign-extend otherwise, zero for R-type.
module instr_decode_seq_imm_extend
   import instr_decode_seq_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [5:0]        opcode,
   input  logic [15:0]       imm16,
   output logic [DATA_W-1:0] imm_ext
);

   always_comb begin
      imm_ext = '0;
      case (opcode)
         OP_R:                      imm_ext = '0;
         OP_ANDI, OP_ORI, OP_XORI:  imm_ext = DATA_W'(imm16);
         OP_LUI:                    imm_ext = DATA_W'({imm16, 16'h0000});
         default:                   imm_ext = DATA_W'(signed'(imm16));
      endcase
   end

endmodule

// File: rtl/instr_decode_seq.sv
// Multicycle decode/sequencer between instruction source, register file and
// execute stage. Define ILLEGAL_TRAP_EN to make illegal opcodes trap (sticky).
module instr_decode_seq
   import instr_decode_seq_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int RA_W       = 5,
   parameter int WB_TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [DATA_W-1:0] instr,
   output logic [5:0]        rf_opcode,
   output logic              rf_regwrite,
   output logic [RA_W-1:0]   rf_readreg1,
   output logic [RA_W-1:0]   rf_readreg2,
   output logic [RA_W-1:0]   rf_writereg,
   output logic [DATA_W-1:0] rf_writedata,
   input  logic [DATA_W-1:0] rf_readdata1,
   input  logic [DATA_W-1:0] rf_readdata2,
   output logic              ex_valid,
   input  logic              ex_ready,
   output logic [5:0]        ex_opcode,
   output logic [5:0]        ex_funct,
   output logic [4:0]        ex_shamt,
   output logic [DATA_W-1:0] ex_a,
   output logic [DATA_W-1:0] ex_b,
   output logic [DATA_W-1:0] ex_imm,
   output logic [25:0]       ex_jtarget,
   input  logic              wb_valid,
   input  logic [DATA_W-1:0] wb_data,
   output logic              wb_ready,
   output logic              illegal,
   output logic              timeout,
   output logic              busy
);

   localparam int CNT_W = $clog2(WB_TIMEOUT) + 1;

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   instr_q, instr_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   ex_a_q, ex_a_d;
   logic [DATA_W-1:0]   ex_b_q, ex_b_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [RA_W-1:0]     wreg_q, wreg_d;
   logic                illegal_q, illegal_d;
   logic                ready_q, ready_d;

   logic [5:0]          op;
   logic [5:0]          funct;
   logic [5:0]          in_op;
   logic [RA_W-1:0]     dest;
   logic                illegal_hit;

   assign op    = instr_q[31:26];
   assign funct = instr_q[5:0];
   assign in_op = instr[31:26];
   assign dest  = (op == OP_R) ? RA_W'(instr_q[15:11]) : RA_W'(instr_q[20:16]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         instr_q   <= '0;
         cnt_q     <= '0;
         ex_a_q    <= '0;
         ex_b_q    <= '0;
         wdata_q   <= '0;
         wreg_q    <= '0;
         illegal_q <= 1'b0;
         ready_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         instr_q   <= instr_d;
         cnt_q     <= cnt_d;
         ex_a_q    <= ex_a_d;
         ex_b_q    <= ex_b_d;
         wdata_q   <= wdata_d;
         wreg_q    <= wreg_d;
         illegal_q <= illegal_d;
         ready_q   <= ready_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      instr_d     = instr_q;
      cnt_d       = cnt_q;
      ex_a_d      = ex_a_q;
      ex_b_d      = ex_b_q;
      wdata_d     = wdata_q;
      wreg_d      = wreg_q;
      illegal_hit = 1'b0;
      rf_opcode   = RF_NOP_OPCODE;
      rf_regwrite = 1'b0;
      rf_readreg1 = '0;
      rf_readreg2 = '0;
      ex_valid    = 1'b0;
      wb_ready    = 1'b0;
      timeout     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (instr_valid && ready_q) begin
               if (in_op == OP_REGIMM) begin
                  illegal_hit = 1'b1;
               end else begin
                  instr_d = instr;
                  state_d = is_jtype(in_op) ? ST_ISSUE : ST_READ;
               end
            end
         end
         ST_READ: begin
            rf_opcode   = RF_RW_OPCODE;
            rf_readreg1 = RA_W'(instr_q[25:21]);
            rf_readreg2 = RA_W'(instr_q[20:16]);
            state_d     = ST_CAPT;
         end
         ST_CAPT: begin
            // Read data is only valid for this one cycle.
            ex_a_d  = rf_readdata1;
            ex_b_d  = rf_readdata2;
            state_d = ST_ISSUE;
         end
         ST_ISSUE: begin
            ex_valid = 1'b1;
            if (ex_ready) begin
               if (no_writeback(op, funct)) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_WB;
                  cnt_d   = '0;
               end
            end
         end
         ST_WB: begin
            wb_ready = 1'b1;
            if (wb_valid) begin
               wdata_d = wb_data;
               wreg_d  = dest;
               state_d = (dest == '0) ? ST_IDLE : ST_WRITE;
            end else if (cnt_q == CNT_W'(WB_TIMEOUT - 1)) begin
               timeout = 1'b1;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_WRITE: begin
            rf_opcode   = RF_RW_OPCODE;
            rf_regwrite = 1'b1;
            state_d     = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

`ifdef ILLEGAL_TRAP_EN
      illegal_d = illegal_q | illegal_hit;
      ready_d   = (state_d == ST_IDLE) && !illegal_d;
`else
      illegal_d = illegal_hit;
      ready_d   = (state_d == ST_IDLE);
`endif
   end

   instr_decode_seq_imm_extend #(
      .DATA_W (DATA_W)
   ) u_imm_extend (
      .opcode  (op),
      .imm16   (instr_q[15:0]),
      .imm_ext (ex_imm)
   );

   assign instr_ready  = ready_q;
   assign illegal      = illegal_q;
   assign busy         = (state_q != ST_IDLE);
   assign rf_writereg  = wreg_q;
   assign rf_writedata = wdata_q;
   assign ex_opcode    = op;
   assign ex_funct     = funct;
   assign ex_shamt     = instr_q[10:6];
   assign ex_a         = ex_a_q;
   assign ex_b         = ex_b_q;
   assign ex_jtarget   = instr_q[25:0];

endmodule

// File: tb/tb_instr_decode_seq.sv
// Randomized self-checking bench for instr_decode_seq with a register-file
// model and a field-level reference model of the decode rules.
module tb_instr_decode_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        instr_valid = 1'b0;
   logic        instr_ready;
   logic [31:0] instr = '0;
   logic [5:0]  rf_opcode;
   logic        rf_regwrite;
   logic [4:0]  rf_readreg1, rf_readreg2, rf_writereg;
   logic [31:0] rf_writedata;
   logic [31:0] rd1 = '0, rd2 = '0;
   logic        ex_valid;
   logic        ex_ready = 1'b0;
   logic [5:0]  ex_opcode, ex_funct;
   logic [4:0]  ex_shamt;
   logic [31:0] ex_a, ex_b, ex_imm;
   logic [25:0] ex_jtarget;
   logic        wb_valid = 1'b0;
   logic [31:0] wb_data = '0;
   logic        wb_ready, illegal, timeout, busy;

   int pass_cnt = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   instr_decode_seq dut (
      .clk(clk), .rst_n(rst_n),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
      .rf_opcode(rf_opcode), .rf_regwrite(rf_regwrite),
      .rf_readreg1(rf_readreg1), .rf_readreg2(rf_readreg2),
      .rf_writereg(rf_writereg), .rf_writedata(rf_writedata),
      .rf_readdata1(rd1), .rf_readdata2(rd2),
      .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_opcode(ex_opcode), .ex_funct(ex_funct), .ex_shamt(ex_shamt),
      .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm), .ex_jtarget(ex_jtarget),
      .wb_valid(wb_valid), .wb_data(wb_data), .wb_ready(wb_ready),
      .illegal(illegal), .timeout(timeout), .busy(busy)
   );

   // Register file environment: registered read, zero outside a read cycle.
   logic [31:0] rf [32];
   logic        pre_we = 1'b0;
   logic [4:0]  pre_addr = '0;
   logic [31:0] pre_data = '0;
   always @(posedge clk) begin
      if (pre_we) rf[pre_addr] <= pre_data;
      else if (rf_regwrite && rf_writereg != 5'd0) rf[rf_writereg] <= rf_writedata;
      if (rf_opcode == 6'd0 && !rf_regwrite) begin
         rd1 <= rf[rf_readreg1];
         rd2 <= rf[rf_readreg2];
      end else begin
         rd1 <= '0;
         rd2 <= '0;
      end
   end

   // Reference model state: architectural register contents.
   logic [31:0] mregs [32];

   function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input int sh, input int fn);
      return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
   endfunction

   function automatic logic [31:0] itype(input int op, input int rs, input int rt, input int imm);
      return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
   endfunction

   function automatic logic [31:0] model_imm(input logic [31:0] ins);
      logic [5:0]  op;
      logic [15:0] im;
      op = ins[31:26];
      im = ins[15:0];
      if (op == 6'd0) return 32'd0;
      if (op >= 6'd12 && op <= 6'd14) return {16'd0, im};
      if (op == 6'd15) return {im, 16'd0};
      return {{16{im[15]}}, im};
   endfunction

   function automatic bit model_has_wb(input logic [31:0] ins);
      int op;
      op = int'(ins[31:26]);
      if (op == 2 || op == 3 || op == 4 || op == 5 || op == 43) return 1'b0;
      if (op == 0) return ins[5:0] != 6'h08;
      return 1'b1;
   endfunction

   function automatic int model_dest(input logic [31:0] ins);
      return (ins[31:26] == 6'd0) ? int'(ins[15:11]) : int'(ins[20:16]);
   endfunction

   function automatic bit model_jump(input logic [31:0] ins);
      return ins[31:26] == 6'd2 || ins[31:26] == 6'd3;
   endfunction

   // Observations of the most recent transaction.
   int          obs_hung, obs_read, obs_nonnop, obs_nwrite, obs_nto, obs_nill;
   int          obs_excyc, obs_hscyc, obs_wcyc, obs_endcyc, obs_nwb, obs_unstable;
   logic [4:0]  obs_wreg;
   logic [31:0] obs_wdata, obs_ex_a, obs_ex_b, obs_ex_imm;
   logic [5:0]  obs_ex_op, obs_ex_fn;
   logic [4:0]  obs_ex_sh;
   logic [25:0] obs_ex_jt;
   int          txn_no = 0;

   task automatic exec(input logic [31:0] ins, input logic [31:0] wdata, input int wdelay,
                       input int exhold, input bit withhold);
      int  n, exw, wbw;
      bit  done;
      obs_hung = 0; obs_read = 0; obs_nonnop = 0; obs_nwrite = 0; obs_nto = 0; obs_nill = 0;
      obs_excyc = -1; obs_hscyc = -1; obs_wcyc = -1; obs_endcyc = -1; obs_nwb = 0; obs_unstable = 0;
      obs_wreg = '0; obs_wdata = '0;
      n = 0;
      while (!instr_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!instr_ready) obs_hung = 1;
      instr = ins;
      instr_valid = 1'b1;
      @(negedge clk);
      instr_valid = 1'b0;
      instr = $urandom;
      exw = 0; wbw = 0; done = 0;
      for (int c = 1; c < 400 && !done; c++) begin
         if (rf_opcode == 6'd0 && !rf_regwrite) obs_read++;
         if (rf_opcode != 6'd2) obs_nonnop++;
         if (rf_regwrite) begin
            obs_nwrite++;
            obs_wreg = rf_writereg;
            obs_wdata = rf_writedata;
            obs_wcyc = c;
         end
         if (timeout) obs_nto++;
         if (illegal) obs_nill++;
         if (ex_valid) begin
            if (obs_excyc < 0) begin
               obs_excyc = c;
               obs_ex_a = ex_a; obs_ex_b = ex_b; obs_ex_imm = ex_imm;
               obs_ex_op = ex_opcode; obs_ex_fn = ex_funct; obs_ex_sh = ex_shamt; obs_ex_jt = ex_jtarget;
            end else if ({ex_a, ex_b, ex_imm, ex_opcode, ex_funct, ex_shamt, ex_jtarget} !==
                         {obs_ex_a, obs_ex_b, obs_ex_imm, obs_ex_op, obs_ex_fn, obs_ex_sh, obs_ex_jt}) begin
               obs_unstable++;
            end
            ex_ready = (exw >= exhold);
            if (ex_ready) obs_hscyc = c;
            exw++;
         end else begin
            ex_ready = 1'($urandom_range(0, 1));
         end
         if (wb_ready) begin
            obs_nwb++;
            wb_valid = !withhold && (wbw >= wdelay);
            wb_data = wb_valid ? wdata : $urandom;
            wbw++;
         end else begin
            wb_valid = 1'($urandom_range(0, 1));
            wb_data = $urandom;
         end
         if (!busy) begin
            obs_endcyc = c;
            done = 1;
         end else begin
            @(negedge clk);
         end
      end
      ex_ready = 1'b0;
      wb_valid = 1'b0;
      if (!done) obs_hung = 1;
      txn_no++;
      $display("txn %0d instr=%08h ex_cyc=%0d writes=%0d wreg=%0d wdata=%08h timeouts=%0d illegal=%0d",
               txn_no, ins, obs_excyc, obs_nwrite, obs_wreg, obs_wdata, obs_nto, obs_nill);
   endtask

   task automatic model_commit(input logic [31:0] ins, input logic [31:0] wdata);
      if (model_has_wb(ins) && model_dest(ins) != 0) mregs[model_dest(ins)] = wdata;
   endtask

   task automatic preload();
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         pre_we = 1'b1;
         pre_addr = 5'(i);
         pre_data = (i == 0) ? 32'd0 : (i == 1) ? 32'd5 : (i == 2) ? 32'd7 : $urandom;
         mregs[i] = pre_data;
      end
      @(negedge clk);
      pre_we = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      total_cnt++;
      if ({instr_ready, ex_valid, wb_ready, busy, illegal, timeout, rf_regwrite} !== 7'b0)
         $display("FAIL reset_ctrl: got %b want 0000000",
                  {instr_ready, ex_valid, wb_ready, busy, illegal, timeout, rf_regwrite});
      else pass_cnt++;
      total_cnt++;
      if (rf_opcode !== 6'd2) $display("FAIL reset_rf_opcode: got %0d want 2", rf_opcode);
      else pass_cnt++;
      total_cnt++;
      if ({ex_a, ex_b, ex_imm, ex_jtarget, rf_writedata, rf_writereg} !== '0)
         $display("FAIL reset_data: ex_a=%h ex_b=%h wdata=%h want 0", ex_a, ex_b, rf_writedata);
      else pass_cnt++;
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_add();
      logic [31:0] ins;
      ins = rtype(1, 2, 3, 0, 32'h20);
      exec(ins, 32'd12, 0, 0, 1'b0);
      model_commit(ins, 32'd12);
      total_cnt++;
      if (obs_excyc !== 3) $display("FAIL add_latency: ex_valid at cycle %0d want 3", obs_excyc);
      else pass_cnt++;
      total_cnt++;
      if (obs_ex_a !== 32'd5 || obs_ex_b !== 32'd7)
         $display("FAIL add_operands: a=%0d b=%0d want 5 7", obs_ex_a, obs_ex_b);
      else pass_cnt++;
      total_cnt++;
      if (obs_nwrite !== 1 || obs_wreg !== 5'd3 || obs_wdata !== 32'd12)
         $display("FAIL add_write: n=%0d reg=%0d data=%0d want 1 3 12", obs_nwrite, obs_wreg, obs_wdata);
      else pass_cnt++;
      total_cnt++;
      if (obs_wcyc !== obs_hscyc + 2)
         $display("FAIL add_wb_latency: write cycle %0d want %0d", obs_wcyc, obs_hscyc + 2);
      else pass_cnt++;
   endtask

   task automatic test_imm();
      logic [31:0] ins [3];
      logic [31:0] want [3];
      ins[0] = itype(8, 1, 4, 16'hFFFF);  want[0] = 32'hFFFFFFFF;
      ins[1] = itype(13, 1, 5, 16'hFFFF); want[1] = 32'h0000FFFF;
      ins[2] = itype(15, 0, 6, 16'h1234); want[2] = 32'h12340000;
      for (int i = 0; i < 3; i++) begin
         logic [31:0] wd;
         wd = $urandom;
         exec(ins[i], wd, 1, 1, 1'b0);
         model_commit(ins[i], wd);
         total_cnt++;
         if (obs_ex_imm !== want[i])
            $display("FAIL imm_ext[%0d]: got %08h want %08h", i, obs_ex_imm, want[i]);
         else pass_cnt++;
         total_cnt++;
         if (obs_nwrite !== 1 || obs_wreg !== 5'(model_dest(ins[i])) || obs_wdata !== wd)
            $display("FAIL imm_write[%0d]: n=%0d reg=%0d data=%h want 1 %0d %h",
                     i, obs_nwrite, obs_wreg, obs_wdata, model_dest(ins[i]), wd);
         else pass_cnt++;
      end
   endtask

   task automatic test_store_branch();
      logic [31:0] ins [2];
      ins[0] = itype(43, 1, 2, 16'h0010);
      ins[1] = itype(4, 2, 1, 16'hFFF0);
      for (int i = 0; i < 2; i++) begin
         exec(ins[i], 32'hDEAD0000, 0, i, 1'b0);
         total_cnt++;
         if (obs_ex_b !== mregs[ins[i][20:16]])
            $display("FAIL sb_rt_value[%0d]: got %h want %h", i, obs_ex_b, mregs[ins[i][20:16]]);
         else pass_cnt++;
         total_cnt++;
         if (obs_nwrite !== 0 || obs_nwb !== 0)
            $display("FAIL sb_no_write[%0d]: writes=%0d wb_cycles=%0d want 0 0", i, obs_nwrite, obs_nwb);
         else pass_cnt++;
         total_cnt++;
         if (obs_endcyc !== obs_hscyc + 1)
            $display("FAIL sb_idle_after_hs[%0d]: idle at %0d want %0d", i, obs_endcyc, obs_hscyc + 1);
         else pass_cnt++;
      end
   endtask

   task automatic test_jump();
      exec({6'd2, 26'h0ABCDEF}, 32'h0, 0, 2, 1'b0);
      total_cnt++;
      if (obs_read !== 0 || obs_nonnop !== 0)
         $display("FAIL jump_no_read: read_cycles=%0d non_nop=%0d want 0 0", obs_read, obs_nonnop);
      else pass_cnt++;
      total_cnt++;
      if (obs_ex_jt !== 26'h0ABCDEF || obs_excyc !== 1)
         $display("FAIL jump_target: jt=%h cyc=%0d want 0abcdef 1", obs_ex_jt, obs_excyc);
      else pass_cnt++;
   endtask

   task automatic test_rd0_timeout();
      exec(rtype(1, 2, 0, 0, 32'h20), 32'h55, 0, 0, 1'b0);
      total_cnt++;
      if (obs_nwrite !== 0 || obs_nwb !== 1)
         $display("FAIL rd0_skip: writes=%0d wb_cycles=%0d want 0 1", obs_nwrite, obs_nwb);
      else pass_cnt++;
      exec(rtype(2, 1, 9, 3, 32'h22), 32'h66, 0, 0, 1'b1);
      total_cnt++;
      if (obs_nto !== 1 || obs_nwrite !== 0 || obs_hung !== 0)
         $display("FAIL wb_timeout: timeouts=%0d writes=%0d hung=%0d want 1 0 0", obs_nto, obs_nwrite, obs_hung);
      else pass_cnt++;
      total_cnt++;
      if (obs_nwb !== 64) $display("FAIL wb_timeout_len: wb_cycles=%0d want 64", obs_nwb);
      else pass_cnt++;
   endtask

   task automatic test_illegal();
      exec(itype(1, 3, 1, 16'h0004), 32'h0, 0, 0, 1'b0);
      total_cnt++;
      if (obs_nill !== 1 || obs_excyc !== -1 || obs_endcyc !== 1)
         $display("FAIL illegal_pulse: illegal=%0d ex_cyc=%0d idle_at=%0d want 1 -1 1",
                  obs_nill, obs_excyc, obs_endcyc);
      else pass_cnt++;
      repeat (3) @(negedge clk);
`ifdef ILLEGAL_TRAP_EN
      total_cnt++;
      if (illegal !== 1'b1 || instr_ready !== 1'b0)
         $display("FAIL illegal_sticky: illegal=%b ready=%b want 1 0", illegal, instr_ready);
      else pass_cnt++;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
`endif
      total_cnt++;
      if (illegal !== 1'b0 || instr_ready !== 1'b1)
         $display("FAIL illegal_recover: illegal=%b ready=%b want 0 1", illegal, instr_ready);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid_wb();
      int n;
      n = 0;
      while (!instr_ready && n < 20) begin @(negedge clk); n++; end
      instr = rtype(1, 2, 6, 0, 32'h20);
      instr_valid = 1'b1;
      @(negedge clk);
      instr_valid = 1'b0;
      ex_ready = 1'b1;
      n = 0;
      while (!wb_ready && n < 20) begin @(negedge clk); n++; end
      ex_ready = 1'b0;
      total_cnt++;
      if (wb_ready !== 1'b1) $display("FAIL rst_wb_reach: wb_ready=%b want 1", wb_ready);
      else pass_cnt++;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      total_cnt++;
      if ({busy, wb_ready, ex_valid, rf_regwrite, instr_ready} !== 5'b0 || rf_opcode !== 6'd2 ||
          rf_writereg !== 5'd0 || rf_writedata !== 32'd0 || ex_a !== 32'd0)
         $display("FAIL rst_mid_wb: ctrl=%b rf_op=%0d wreg=%0d wdata=%h ex_a=%h want 0 2 0 0 0",
                  {busy, wb_ready, ex_valid, rf_regwrite, instr_ready}, rf_opcode, rf_writereg,
                  rf_writedata, ex_a);
      else pass_cnt++;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      total_cnt++;
      if (rf[6] !== mregs[6]) $display("FAIL rst_no_write: r6=%h want %h", rf[6], mregs[6]);
      else pass_cnt++;
   endtask

   task automatic test_random();
      int ops [16] = '{0, 0, 0, 2, 3, 4, 5, 8, 9, 10, 12, 13, 14, 15, 35, 43};
      int fns [6]  = '{32, 34, 36, 8, 42, 0};
      for (int t = 0; t < 40; t++) begin
         logic [31:0] ins, wd;
         int          op, errs;
         bit          wb_exp;
         op = ops[$urandom_range(0, 15)];
         ins = $urandom;
         ins[31:26] = 6'(op);
         if (op == 0) ins[5:0] = 6'(fns[$urandom_range(0, 5)]);
         wd = $urandom;
         exec(ins, wd, $urandom_range(0, 4), $urandom_range(0, 3), 1'b0);
         wb_exp = model_has_wb(ins) && model_dest(ins) != 0;
         errs = 0;
         if (obs_hung != 0 || obs_unstable != 0) errs++;
         if (obs_excyc != (model_jump(ins) ? 1 : 3)) errs++;
         if (obs_ex_op !== ins[31:26] || obs_ex_fn !== ins[5:0] || obs_ex_sh !== ins[10:6] ||
             obs_ex_jt !== ins[25:0] || obs_ex_imm !== model_imm(ins)) errs++;
         if (!model_jump(ins) && (obs_ex_a !== mregs[ins[25:21]] || obs_ex_b !== mregs[ins[20:16]])) errs++;
         if (obs_read != (model_jump(ins) ? 0 : 1)) errs++;
         if (obs_nwrite != (wb_exp ? 1 : 0)) errs++;
         if (wb_exp && (obs_wreg !== 5'(model_dest(ins)) || obs_wdata !== wd)) errs++;
         total_cnt++;
         if (errs != 0)
            $display("FAIL random[%0d]: instr=%08h errors=%0d ex_cyc=%0d a=%h b=%h imm=%h writes=%0d wreg=%0d want_imm=%h want_write=%0d",
                     t, ins, errs, obs_excyc, obs_ex_a, obs_ex_b, obs_ex_imm, obs_nwrite, obs_wreg,
                     model_imm(ins), wb_exp);
         else pass_cnt++;
         model_commit(ins, wd);
      end
   endtask

   task automatic test_final_regs();
      int bad;
      bad = 0;
      for (int i = 0; i < 32; i++) if (rf[i] !== mregs[i]) bad++;
      total_cnt++;
      if (bad != 0) $display("FAIL final_regs: %0d registers differ from model, want 0", bad);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      preload();
      test_add();
      test_imm();
      test_store_branch();
      test_jump();
      test_rd0_timeout();
      test_illegal();
      test_reset_mid_wb();
      test_random();
      test_final_regs();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/instr_decode_seq.md
Name: instr_decode_seq

Overview:
- Multicycle decode/sequencer stage directly upstream of the register file.
- Accepts one 32-bit MIPS instruction per transaction and splits it into fields.
- Drives the register file's opcode/Regwrite/address/data inputs to read operands, captures the read data, and issues the operands to the execute stage.
- Collects the execute result and writes it back to the register file.

Parameters:
- DATA_W, 32, datapath and instruction width.
- RA_W, 5, register address width.
- WB_TIMEOUT, 64, maximum cycles spent in WB waiting for wb_valid before aborting.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  stage can accept an instruction.
- instr  in  DATA_W  instruction word.
- rf_opcode  out  6  register file opcode input.
- rf_regwrite  out  1  register file Regwrite.
- rf_readreg1  out  RA_W  rs address.
- rf_readreg2  out  RA_W  rt address.
- rf_writereg  out  RA_W  destination address.
- rf_writedata  out  DATA_W  write-back data.
- rf_readdata1  in  DATA_W  register file ReadData1.
- rf_readdata2  in  DATA_W  register file ReadData2.
- ex_valid  out  1  operand bundle valid.
- ex_ready  in  1  execute stage accepts the bundle.
- ex_opcode  out  6  instr[31:26].
- ex_funct  out  6  instr[5:0].
- ex_shamt  out  5  instr[10:6].
- ex_a  out  DATA_W  rs value.
- ex_b  out  DATA_W  rt value.
- ex_imm  out  DATA_W  extended immediate.
- ex_jtarget  out  26  instr[25:0].
- wb_valid  in  1  execute result valid.
- wb_data  in  DATA_W  execute result.
- wb_ready  out  1  result consumed.
- illegal  out  1  illegal-opcode indication.
- timeout  out  1  one-cycle pulse on write-back timeout.
- busy  out  1  FSM not in IDLE.

Behaviour:
- States: IDLE, READ, CAPT, ISSUE, WB, WRITE.
- Reset (async, rst_n=0): state IDLE; all outputs 0 except rf_opcode=6'd2; instruction register cleared; timeout counter cleared. Reset mid-operation abandons the instruction without any write.
- rf_opcode/rf_regwrite per state:
  - READ: 6'd0, regwrite 0 (both ports read, including for I-type).
  - WRITE: 6'd0, regwrite 1.
  - All other states: 6'd2 (J no-op), regwrite 0, so the register file is untouched.
- IDLE: instr_ready=1. On instr_valid, latch instr. Next state:
  - opcode 2/3 (J type): ISSUE.
  - opcode 1: illegal; assert illegal for one cycle, drop the instruction, stay in IDLE.
  - otherwise: READ.
- READ: drive rs=instr[25:21], rt=instr[20:16]. Always go to CAPT.
- CAPT: register-file data is valid only in this cycle (the file zeroes it on the following edges).
  - ex_a <= rf_readdata1; ex_b <= rf_readdata2.
  - Go to ISSUE.
- ISSUE: ex_valid=1. All ex_* outputs stay stable until ex_valid&ex_ready. On that handshake:
  - J type, beq 0x04, bne 0x05, sw 0x2B, or R-type funct 0x08: go to IDLE.
  - All others: go to WB and clear the counter.
- Immediate extension: zero-extend instr[15:0] for opcodes 0x0C–0x0E; for 0x0F, {instr[15:0],16'b0}; otherwise sign-extend. For R-type, ex_imm=0.
- WB: wb_ready=1.
  - On wb_valid: latch wb_data into rf_writedata.
    - Destination is rd (instr[15:11]) for R-type, rt for I-type.
    - Destination 0: skip the write and go to IDLE.
    - Otherwise: go to WRITE.
  - If WB_TIMEOUT cycles elapse without wb_valid: pulse timeout, go to IDLE, no write.
- WRITE: one cycle with rf_regwrite=1; then IDLE.
- Latency: R-type accepted at cycle 0 → READ at 1 → CAPT at 2 → ex_valid at 3. Minimum issue-to-write is 2 cycles after the ex handshake.
- busy = (state != IDLE).

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined: an illegal opcode sets illegal as a sticky flag and forces instr_ready=0 permanently until rst_n.
- Undefined: illegal is a one-cycle pulse and the stage keeps accepting instructions.

Decomposition:
- Shared package holds:
  - opcode constants: R 0x00, REGIMM 0x01, J 0x02, JAL 0x03, BEQ 0x04, BNE 0x05, ANDI..LUI 0x0C–0x0F, SW 0x2B.
  - FUNCT_JR 0x08.
  - the FSM state enum.
  - the RF_NOP_OPCODE constant (6'd2).
- One natural sub-module, imm_extend: combinational extender (opcode, imm16 → DATA_W).

Test Plan:
- add $3,$1,$2 with $1=5, $2=7 preloaded; wb_data=12 → ex_valid at cycle 3, ex_a=5, ex_b=7, then the write cycle has rf_writereg=3 and rf_writedata=12.
- addi $4,$1,-1 (imm 0xFFFF) → ex_imm=0xFFFFFFFF. ori with 0xFFFF → ex_imm=0x0000FFFF. lui 0x1234 → ex_imm=0x12340000.
- sw and beq → ex_b carries the rt value; rf_regwrite is never asserted; back in IDLE right after the ex handshake.
- j 0x0ABCDEF → no READ cycle; ex_jtarget=0x0ABCDEF; rf_opcode stays 2 throughout.
- R-type with rd=0, then an R-type with wb_valid withheld for 64 cycles → no write for either; timeout pulses once; FSM returns to IDLE.
- Opcode 1 → illegal pulse (sticky with ILLEGAL_TRAP_EN); rst_n asserted during WB → all outputs return to reset values immediately and no write occurs.
